// File: rtl/seq_serializer.sv
// seq_serializer: FIFO-buffered, MSB-first parallel-to-serial feeder.
// Optional SER_PARITY_EN appends an even-parity bit after each word.
module seq_serializer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] shift_nx, head;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              push, pop, load;
  logic              word_end, not_empty;
`ifdef SER_PARITY_EN
  logic              par_q, par_d;
`endif

  assign in_ready   = rst_n && (count_q != FULL);
  assign push       = in_valid && in_ready;
  assign pop        = load;
  assign not_empty  = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign shift_nx   = shift_q << 1;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign fifo_level = count_q;

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    if (push && !pop)
      count_d = count_q + LVL_W'(1);
    else if (pop && !push)
      count_d = count_q - LVL_W'(1);
  end

  // Serializer FSM: shift, reload without gap, or fall back to idle
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    dout_d   = 1'b0;
    dv_d     = 1'b0;
    word_end = 1'b0;
    load     = 1'b0;
`ifdef SER_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      IDLE: load = not_empty;
      SHIFT: begin
        if (bitcnt_q != '0) begin
          shift_d  = shift_nx;
          bitcnt_d = bitcnt_q - CNT_W'(1);
          dout_d   = shift_nx[DATA_W-1];
          dv_d     = 1'b1;
        end else begin
`ifdef SER_PARITY_EN
          state_d = PARITY;
          dout_d  = par_q;
          dv_d    = 1'b1;
`else
          word_end = 1'b1;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: word_end = 1'b1;
`endif
      default: state_d = IDLE;
    endcase
    if (word_end) begin
      if (not_empty) begin
        load = 1'b1;
      end else begin
        state_d  = IDLE;
        shift_d  = '0;
        bitcnt_d = '0;
      end
    end
    if (load) begin
      state_d  = SHIFT;
      shift_d  = head;
      bitcnt_d = LAST;
      dout_d   = head[DATA_W-1];
      dv_d     = 1'b1;
`ifdef SER_PARITY_EN
      par_d    = ^head;
`endif
    end
  end

  // Word storage; writes only on an accepted push
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= in_data;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      dout_q   <= 1'b0;
      dv_q     <= 1'b0;
`ifdef SER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
`ifdef SER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: randomized and directed bench for seq_serializer.
// Reference model tracks each word's push edge and serial start edge.
module tb_seq_serializer;
  localparam int W = 8;
  localparam int D = 4;
`ifdef SER_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         dout;
  logic         dout_valid;
  logic [2:0]   fifo_level;

  int vectors = 0;
  int fails = 0;
  int edge_n = 0;
  int last_start = -1000;
  int q_push[$];
  int q_start[$];
  logic [W-1:0] q_word[$];

  seq_serializer #(.DATA_W(W), .DEPTH(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dout(dout),
    .dout_valid(dout_valid),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Expected {dout, dout_valid, fifo_level, in_ready} after edge edge_n.
  function automatic logic [5:0] exp_vec();
    int lvl = 0;
    logic b = 1'b0;
    logic v = 1'b0;
    foreach (q_push[i]) begin
      if (q_push[i] <= edge_n && q_start[i] > edge_n) lvl++;
      if (q_start[i] <= edge_n && edge_n < q_start[i] + L) begin
        int k;
        logic [W-1:0] w;
        k = edge_n - q_start[i];
        w = q_word[i];
        v = 1'b1;
        b = (k < W) ? w[W-1-k] : ^w;
      end
    end
    return {b, v, 3'(lvl), rst_n && (lvl != D)};
  endfunction

  function automatic logic [17:0] bits_of(input logic [W-1:0] w);
    return (L == W) ? 18'(w) : 18'({w, ^w});
  endfunction

  // Drive one cycle and advance the reference model.
  task automatic step(input logic v, input logic [W-1:0] d,
                      output logic acc);
    logic [5:0] e;
    int s;
    e = exp_vec();
    acc = v && e[0];
    in_valid = v;
    in_data = d;
    @(posedge clk);
    edge_n++;
    if (!rst_n) begin
      q_push.delete();
      q_start.delete();
      q_word.delete();
      last_start = -1000;
    end else if (acc) begin
      s = (edge_n + 1 > last_start + L) ? edge_n + 1 : last_start + L;
      last_start = s;
      q_push.push_back(edge_n);
      q_start.push_back(s);
      q_word.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic acc;
    logic [5:0] got, exp;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, W'($urandom), acc);
      got = {dout, dout_valid, fifo_level, in_ready};
      exp = exp_vec();
      vectors++;
      if (got !== exp) begin
        fails++;
        $display("FAIL reset cyc %0d: got %b want %b", edge_n, got, exp);
      end
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    logic acc;
    logic [5:0] got, exp;
    logic [17:0] col = '0;
    int nv = 0;
    step(1'b1, 8'hB4, acc);
    for (int c = 0; c < 14; c++) begin
      if (c > 0) step(1'b0, '0, acc);
      got = {dout, dout_valid, fifo_level, in_ready};
      exp = exp_vec();
      vectors++;
      if (got !== exp) begin
        fails++;
        $display("FAIL single cyc %0d: got %b want %b", edge_n, got, exp);
      end
      if (dout_valid) begin
        col = {col[16:0], dout};
        nv++;
      end
    end
    vectors++;
    if (nv != L || col !== bits_of(8'hB4)) begin
      fails++;
      $display("FAIL single_stream: got %0d bits %h want %0d bits %h",
               nv, col, L, bits_of(8'hB4));
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [5:0] got, exp;
    logic [17:0] col = '0;
    logic [17:0] want;
    int nv = 0;
    int gap = 0;
    want = (bits_of(8'hB4) << L) | bits_of(8'h3C);
    for (int c = 0; c < 24; c++) begin
      if (c == 0) step(1'b1, 8'hB4, acc);
      else if (c == 1) step(1'b1, 8'h3C, acc);
      else step(1'b0, '0, acc);
      got = {dout, dout_valid, fifo_level, in_ready};
      exp = exp_vec();
      vectors++;
      if (got !== exp) begin
        fails++;
        $display("FAIL b2b cyc %0d: got %b want %b", edge_n, got, exp);
      end
      if (dout_valid) begin
        if (nv > 0 && gap > 0) gap = 99;
        col = {col[16:0], dout};
        nv++;
      end else if (nv > 0) begin
        gap++;
      end
    end
    vectors++;
    if (nv != 2 * L || gap == 99 || col !== want) begin
      fails++;
      $display("FAIL b2b_stream: got %0d bits %h want %0d bits %h",
               nv, col, 2 * L, want);
    end
  endtask

  task automatic test_full();
    logic acc;
    logic [5:0] got, exp;
    logic [W-1:0] words [6];
    int idx = 0;
    int peak = 0;
    for (int i = 0; i < 6; i++) words[i] = W'($urandom);
    for (int c = 0; c < 40 && idx < 6; c++) begin
      step(1'b1, words[idx], acc);
      if (acc) idx++;
      got = {dout, dout_valid, fifo_level, in_ready};
      exp = exp_vec();
      vectors++;
      if (got !== exp) begin
        fails++;
        $display("FAIL full cyc %0d: got %b want %b", edge_n, got, exp);
      end
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    vectors++;
    if (idx != 6 || peak != D) begin
      fails++;
      $display("FAIL full_accept: got %0d words peak %0d want 6 words peak %0d",
               idx, peak, D);
    end
    for (int c = 0; c < 50; c++) begin
      step(1'b0, '0, acc);
      got = {dout, dout_valid, fifo_level, in_ready};
      exp = exp_vec();
      vectors++;
      if (got !== exp) begin
        fails++;
        $display("FAIL full_drain cyc %0d: got %b want %b", edge_n, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    logic [5:0] got, exp;
    step(1'b1, 8'hFF, acc);
    step(1'b1, 8'hA5, acc);
    step(1'b1, 8'h5A, acc);
    step(1'b0, '0, acc);
    step(1'b0, '0, acc);
    vectors++;
    if (fifo_level !== 3'd2 || dout_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_pre: got level %0d dv %b want level 2 dv 1",
               fifo_level, dout_valid);
    end
    rst_n = 1'b0;
    step(1'b1, 8'h81, acc);
    vectors++;
    if ({dout, dout_valid, fifo_level} !== 5'b0) begin
      fails++;
      $display("FAIL mid_reset: got %b want 00000",
               {dout, dout_valid, fifo_level});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      step(1'b0, '0, acc);
      got = {dout, dout_valid, fifo_level, in_ready};
      exp = exp_vec();
      vectors++;
      if (got !== exp) begin
        fails++;
        $display("FAIL mid_after cyc %0d: got %b want %b", edge_n, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic acc;
    logic v;
    logic hold = 1'b0;
    logic [W-1:0] pend = '0;
    logic [5:0] got, exp;
    for (int c = 0; c < 460; c++) begin
      if (!hold) begin
        if (c < 200) v = ($urandom_range(0, 3) != 0);
        else if (c < 400) v = ($urandom_range(0, 9) == 0);
        else v = 1'b0;
        pend = W'($urandom);
      end else begin
        v = 1'b1;
      end
      step(v, pend, acc);
      hold = v && !acc;
      got = {dout, dout_valid, fifo_level, in_ready};
      exp = exp_vec();
      vectors++;
      if (got !== exp) begin
        fails++;
        $display("FAIL random cyc %0d: got %b want %b", edge_n, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
